// File: rtl/playfield_board_pkg.sv
// Shared game constants for the screen, block and scoring logic.
//   BOARD_COLS / BOARD_ROWS : default playfield size in cells (row 0 is the top)
//   COL_W / ROW_W           : widths of the column and row coordinates
//   BCD_DIGIT_W / BCD_DIGITS: layout of the packed BCD score
//   boardState_e            : playfield controller state encoding
//   bcdIncrement()          : saturating +1 on a packed BCD score
package playfield_board_pkg;

  localparam int BOARD_COLS  = 10;
  localparam int BOARD_ROWS  = 20;
  localparam int COL_W       = 4;
  localparam int ROW_W       = 5;
  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_DIGITS  = 4;
  localparam int SCORE_W     = BCD_DIGIT_W * BCD_DIGITS;

  localparam logic [SCORE_W-1:0] SCORE_MAX = {BCD_DIGITS{BCD_DIGIT_W'(9)}};

  typedef enum logic [2:0] {
    IDLE,
    LOCK,
    SCAN,
    SHIFT,
    CHECK
  } boardState_e;

  // Adds one to a packed BCD value, rippling the decimal carry from the
  // units digit upward. A score already at all nines is returned unchanged.
  function automatic logic [SCORE_W-1:0] bcdIncrement(input logic [SCORE_W-1:0] value);
    logic [SCORE_W-1:0]     result;
    logic [BCD_DIGIT_W-1:0] digit;
    logic                   carry;
    result = value;
    carry  = 1'b1;
    if (value != SCORE_MAX) begin
      for (int d = 0; d < BCD_DIGITS; d++) begin
        digit = value[d*BCD_DIGIT_W +: BCD_DIGIT_W];
        if (carry) begin
          if (digit == BCD_DIGIT_W'(9)) begin
            result[d*BCD_DIGIT_W +: BCD_DIGIT_W] = '0;
          end else begin
            result[d*BCD_DIGIT_W +: BCD_DIGIT_W] = digit + BCD_DIGIT_W'(1);
            carry = 1'b0;
          end
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/playfield_board_if.sv
// Bus between the game logic and the playfield board.
//   lock_valid / lock_ready : lock handshake for the falling piece
//   x1..x4, y1..y4          : column / row of each of the four piece cells
//   qx, qy / q_occupied     : cell occupancy query (combinational answer)
//   busy, line_pulse        : board activity and one pulse per cleared row
//   score_bcd, game_over    : four-digit BCD line count and sticky top-out flag
// The master modport is the game logic side, the slave modport is the board.
interface playfield_board_if;
  import playfield_board_pkg::*;

  logic               lock_valid;
  logic               lock_ready;
  logic [COL_W-1:0]   x1;
  logic [COL_W-1:0]   x2;
  logic [COL_W-1:0]   x3;
  logic [COL_W-1:0]   x4;
  logic [ROW_W-1:0]   y1;
  logic [ROW_W-1:0]   y2;
  logic [ROW_W-1:0]   y3;
  logic [ROW_W-1:0]   y4;
  logic [COL_W-1:0]   qx;
  logic [ROW_W-1:0]   qy;
  logic               q_occupied;
  logic               busy;
  logic               line_pulse;
  logic [SCORE_W-1:0] score_bcd;
  logic               game_over;

  modport master (
    output lock_valid, x1, x2, x3, x4, y1, y2, y3, y4, qx, qy,
    input  lock_ready, q_occupied, busy, line_pulse, score_bcd, game_over
  );

  modport slave (
    input  lock_valid, x1, x2, x3, x4, y1, y2, y3, y4, qx, qy,
    output lock_ready, q_occupied, busy, line_pulse, score_bcd, game_over
  );

endinterface

// File: rtl/playfield_board_bcd_counter4.sv
// Four-digit BCD line counter that stops at 9999.
//   clk, reset : clock and asynchronous active-high reset
//   inc        : add one on this clock edge
//   value      : packed digits {thousands, hundreds, tens, units}
// RESET_VALUE is the count loaded on reset (zero for a normal game).
module bcd_counter4
  import playfield_board_pkg::*;
#(
  parameter logic [SCORE_W-1:0] RESET_VALUE = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  output logic [SCORE_W-1:0] value
);

  logic [SCORE_W-1:0] value_q;
  logic [SCORE_W-1:0] value_d;

  // Next count: hold unless an increment is requested; the package helper
  // handles the decimal carry and the saturation at 9999.
  always_comb begin
    value_d = value_q;
    if (inc) begin
      value_d = bcdIncrement(value_q);
    end
  end

  // Count register; reset drops any increment that was about to land.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= RESET_VALUE;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/playfield_board.sv
// Playfield occupancy board with piece locking and line clearing.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : playfield_board_if slave side
//                lock_valid/lock_ready handshake with cells x1..x4 / y1..y4,
//                qx/qy -> q_occupied query, busy, line_pulse, score_bcd,
//                game_over
// An accepted lock writes the four cells, then rows are scanned bottom-up.
// Each full row is removed by moving every row above it down one place,
// after which the same row is scanned again. A final look at row 0 decides
// whether the stack has reached the top.
module playfield_board
  import playfield_board_pkg::*;
#(
  parameter int                 COLS        = BOARD_COLS,
  parameter int                 ROWS        = BOARD_ROWS,
  parameter logic [SCORE_W-1:0] SCORE_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  playfield_board_if.slave bus
);

  logic [COLS-1:0]    board_q [ROWS];
  boardState_e        state_q;
  logic [ROW_W-1:0]   row_q;
  logic [ROW_W-1:0]   shift_q;
  logic [COL_W-1:0]   pieceX_q [4];
  logic [ROW_W-1:0]   pieceY_q [4];
  logic               gameOver_q;
  logic               linePulse_q;

  logic               lockReady;
  logic               lockAccept;
  logic [3:0]         cellValid;
  logic               overlap;
  logic               rowFull;
  logic               scoreInc;
  logic               queryHit;
  logic [SCORE_W-1:0] score;

  assign lockReady  = (state_q == IDLE) && !gameOver_q;
  assign lockAccept = bus.lock_valid && lockReady;
  assign rowFull    = &board_q[row_q];
  assign scoreInc   = (state_q == SHIFT) && (shift_q == '0);

  // Classify the captured piece cells: a cell off the board is dropped, and
  // an on-board cell that is already set means the piece overlaps the stack.
  always_comb begin
    cellValid = '0;
    overlap   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cellValid[i] = (int'(pieceX_q[i]) < COLS) && (int'(pieceY_q[i]) < ROWS);
      if (cellValid[i] && board_q[pieceY_q[i]][pieceX_q[i]]) begin
        overlap = 1'b1;
      end
    end
  end

  // Query port reads the live array, so a renderer sees rows moving during
  // a clear; addresses off the board read as empty.
  always_comb begin
    queryHit = 1'b0;
    if ((int'(bus.qx) < COLS) && (int'(bus.qy) < ROWS)) begin
      queryHit = board_q[bus.qy][bus.qx];
    end
  end

  // Controller and occupancy array. SCAN checks one row per cycle from the
  // bottom. SHIFT walks shift_q from the full row up to 1, copying the row
  // above into it, and on its last cycle empties row 0, pulses line_pulse
  // and bumps the score; row_q is left alone so the row that just received
  // new contents is scanned again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      row_q       <= ROW_W'(ROWS - 1);
      shift_q     <= '0;
      gameOver_q  <= 1'b0;
      linePulse_q <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        board_q[r] <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        pieceX_q[i] <= '0;
        pieceY_q[i] <= '0;
      end
    end else begin
      linePulse_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (lockAccept) begin
            pieceX_q[0] <= bus.x1;
            pieceX_q[1] <= bus.x2;
            pieceX_q[2] <= bus.x3;
            pieceX_q[3] <= bus.x4;
            pieceY_q[0] <= bus.y1;
            pieceY_q[1] <= bus.y2;
            pieceY_q[2] <= bus.y3;
            pieceY_q[3] <= bus.y4;
            state_q     <= LOCK;
          end
        end
        LOCK: begin
          for (int i = 0; i < 4; i++) begin
            if (cellValid[i]) begin
              board_q[pieceY_q[i]][pieceX_q[i]] <= 1'b1;
            end
          end
          if (overlap) begin
            gameOver_q <= 1'b1;
          end
          row_q   <= ROW_W'(ROWS - 1);
          state_q <= SCAN;
        end
        SCAN: begin
          if (rowFull) begin
            shift_q <= row_q;
            state_q <= SHIFT;
          end else if (row_q == '0) begin
            state_q <= CHECK;
          end else begin
            row_q <= row_q - ROW_W'(1);
          end
        end
        SHIFT: begin
          if (shift_q != '0) begin
            board_q[shift_q] <= board_q[shift_q - ROW_W'(1)];
            shift_q          <= shift_q - ROW_W'(1);
          end else begin
            board_q[0]  <= '0;
            linePulse_q <= 1'b1;
            state_q     <= SCAN;
          end
        end
        CHECK: begin
          if (|board_q[0]) begin
            gameOver_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  bcd_counter4 #(
    .RESET_VALUE(SCORE_RESET)
  ) u_score (
    .clk  (clk),
    .reset(reset),
    .inc  (scoreInc),
    .value(score)
  );

  assign bus.lock_ready = lockReady;
  assign bus.q_occupied = queryHit;
  assign bus.busy       = (state_q != IDLE);
  assign bus.line_pulse = linePulse_q;
  assign bus.score_bcd  = score;
  assign bus.game_over  = gameOver_q;

endmodule

// File: doc/playfield_board.md
PLAYFIELD_BOARD -- requirements
Module: playfield_board

Interface
REQ-001 SHALL have parameter COLS, default 10, playfield width in cells.
REQ-002 SHALL have parameter ROWS, default 20, playfield height in cells; row 0 is the top row.
REQ-003 SHALL have port clk  input  1  the single clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port lock_valid  input  1  request to lock the current falling piece into the board.
REQ-006 SHALL have port lock_ready  output  1  high when a lock request is accepted this cycle.
REQ-007 SHALL have ports x1..x4  input  4 each  column of each piece cell.
REQ-008 SHALL have ports y1..y4  input  5 each  row of each piece cell.
REQ-009 SHALL have ports qx, qy  input  4 and 5  cell query address for renderer and collision logic.
REQ-010 SHALL have port q_occupied  output  1  occupancy of cell (qx,qy), combinational, 0 when out of range.
REQ-011 SHALL have port busy  output  1  high while lock, scan or shift is in progress.
REQ-012 SHALL have port line_pulse  output  1  one-cycle pulse per cleared row.
REQ-013 SHALL have port score_bcd  output  16  four BCD digits {thousands, hundreds, tens, units} of cleared lines.
REQ-014 SHALL have port game_over  output  1  sticky end-of-game flag.

Function
REQ-015 SHALL hold a ROWS x COLS occupancy array with one bit per cell.
REQ-016 SHALL implement FSM states IDLE, LOCK, SCAN, SHIFT, CHECK.
REQ-017 SHALL drive lock_ready = (state==IDLE) && !game_over; a lock occurs only when lock_valid && lock_ready.
REQ-018 SHALL, on an accepted lock, capture x1..y4, go to LOCK, set the 4 cells on the next edge, then enter SCAN with row pointer r = ROWS-1.
REQ-019 SHALL ignore any piece cell with x>=COLS or y>=ROWS; the remaining cells still lock.
REQ-020 SHALL set game_over at LOCK when any in-range captured cell is already occupied; the cells are still written.
REQ-021 SHALL in SCAN test one row per cycle: if row r is full, go to SHIFT; else if r==0 go to CHECK; else decrement r.
REQ-022 SHALL in SHIFT copy row k-1 into row k for k = r down to 1, one row per cycle, then clear row 0, pulse line_pulse, increment score, and return to SCAN at the same r.
REQ-023 SHALL increment score_bcd as a 4-digit BCD counter with decimal carry, saturating at 9999.
REQ-024 SHALL in CHECK set game_over if any cell of row 0 is occupied, then return to IDLE.
REQ-025 SHALL drive busy = (state != IDLE).
REQ-026 SHALL keep q_occupied reflecting the live array, including mid-shift contents.
REQ-027 SHALL keep game_over set until reset; while set, lock requests are never accepted.
REQ-028 SHALL give worst-case latency from lock accept to IDLE of 2 + ROWS + 4*(ROWS+1) cycles for four cleared rows.

Reset
REQ-029 SHALL, on reset assertion, asynchronously clear the array, score_bcd=0, game_over=0, line_pulse=0, state=IDLE, r=ROWS-1.
REQ-030 SHALL abandon any in-progress lock or shift when reset is asserted mid-operation; no partial score update survives.

Structure
REQ-031 SHALL place COLS, ROWS, the FSM state encoding and the BCD digit width in the shared game constants package used by the screen, block and scoring logic.
REQ-032 SHALL implement the 4-digit saturating BCD incrementer as sub-module bcd_counter4 (inputs clk, reset, inc; output 16-bit value).

Verification
REQ-033 SHALL verify empty board: lock cells (0,19),(1,19),(2,19),(3,19) -> those cells occupied, no line_pulse, score 0000, busy for 2+20 cycles.
REQ-034 SHALL verify a single clear: pre-fill row 19 cols 0-5, lock I-piece at cols 6-9 row 19 -> one line_pulse, score 0001, row 19 takes old row 18, row 0 empty.
REQ-035 SHALL verify a four-line clear: rows 16-19 full except col 9, lock vertical I at col 9 rows 16-19 -> four line_pulses, score 0004, rows 16-19 empty.
REQ-036 SHALL verify BCD carry and saturation: preload score 0099, clear one row -> 0100; preload 9999, clear one row -> stays 9999.
REQ-037 SHALL verify overlap and top-out: lock onto an occupied cell -> game_over=1, lock_ready=0 afterwards; a cell left in row 0 after scan -> game_over=1 at CHECK.
REQ-038 SHALL verify lock_valid while busy is ignored, an out-of-range cell (x=12) is dropped, and reset asserted during SHIFT clears the array and score to 0 immediately.
